// File: rtl/regram_xfer_unit.sv
// Scratch-storage/transfer engine: flop register file plus synchronous RAM behind a
// single command port, sequenced by one FSM (read, write, clear, block copy).
module regram_xfer_unit #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [RAM_AW-1:0] ram_addr,
  input  logic [REG_AW-1:0] cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done
);
  localparam int REG_D = 1 << REG_AW;
  localparam int RAM_D = 1 << RAM_AW;

  localparam logic [2:0] OP_REG_RD  = 3'd0;
  localparam logic [2:0] OP_RAM_RD  = 3'd1;
  localparam logic [2:0] OP_REG_WR  = 3'd2;
  localparam logic [2:0] OP_RAM_WR  = 3'd3;
  localparam logic [2:0] OP_REG_CLR = 3'd4;
  localparam logic [2:0] OP_RAM_CLR = 3'd5;
  localparam logic [2:0] OP_CP_M2R  = 3'd6;
  localparam logic [2:0] OP_CP_R2M  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_RAM_RDW, S_CLR, S_CP_RD, S_CP_WR, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [REG_AW-1:0] reg_ptr;
  logic [RAM_AW-1:0] ram_ptr;
  logic [REG_AW-1:0] len_q;
  logic [REG_AW-1:0] cnt;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] regs [REG_D];
  logic [DATA_W-1:0] ram  [RAM_D];
  logic [DATA_W-1:0] ram_q;

  logic              accept;
  logic              clr_last;
  logic              cp_last;
  logic              reg_we;
  logic              ram_we;
  logic [DATA_W-1:0] reg_wd;
  logic [DATA_W-1:0] ram_wd;

  assign accept   = cmd_valid && cmd_ready;
  assign clr_last = (op_q == OP_REG_CLR) ? (&reg_ptr) : (&ram_ptr);
  assign cp_last  = (cnt == len_q);
  assign busy     = ~cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_REG_CLR, OP_RAM_CLR: state_nxt = S_CLR;
            OP_CP_M2R:              state_nxt = S_CP_RD;
            OP_CP_R2M:              state_nxt = S_CP_WR;
            default:                state_nxt = S_EXEC;
          endcase
        end
      end
      S_EXEC:    state_nxt = (op_q == OP_RAM_RD) ? S_RAM_RDW : S_FIN;
      S_RAM_RDW: state_nxt = S_FIN;
      S_CLR:     state_nxt = clr_last ? S_FIN : S_CLR;
      S_CP_RD:   state_nxt = S_CP_WR;
      S_CP_WR: begin
        if (cp_last)                state_nxt = S_FIN;
        else if (op_q == OP_CP_M2R) state_nxt = S_CP_RD;
        else                        state_nxt = S_CP_WR;
      end
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = 1'b0;
    done        = 1'b0;
    rdata_valid = 1'b0;
    reg_we      = 1'b0;
    ram_we      = 1'b0;
    reg_wd      = wdata_q;
    ram_wd      = wdata_q;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        reg_we = (op_q == OP_REG_WR);
        ram_we = (op_q == OP_RAM_WR);
      end
      S_CLR: begin
        reg_we = (op_q == OP_REG_CLR);
        ram_we = (op_q == OP_RAM_CLR);
        reg_wd = '0;
        ram_wd = '0;
      end
      S_CP_WR: begin
        reg_we = (op_q == OP_CP_M2R);
        ram_we = (op_q == OP_CP_R2M);
        reg_wd = ram_q;
        ram_wd = regs[reg_ptr];
      end
      S_FIN: begin
        done        = 1'b1;
        rdata_valid = (op_q == OP_REG_RD) || (op_q == OP_RAM_RD);
      end
      default: ;
    endcase
  end

  // Command fields are captured at acceptance; clears walk both pointers up from zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= cmd_op;
      len_q   <= cmd_len;
      wdata_q <= wdata;
      cnt     <= '0;
      if (cmd_op == OP_REG_CLR || cmd_op == OP_RAM_CLR) begin
        reg_ptr <= '0;
        ram_ptr <= '0;
      end else begin
        reg_ptr <= reg_addr;
        ram_ptr <= ram_addr;
      end
    end else if (state == S_CLR || state == S_CP_WR) begin
      reg_ptr <= reg_ptr + REG_AW'(1);
      ram_ptr <= ram_ptr + RAM_AW'(1);
      cnt     <= cnt + REG_AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_D; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[reg_ptr] <= reg_wd;
    end
  end

  // RAM contents survive reset; the read port is registered (one-cycle latency).
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_ptr] <= ram_wd;
    ram_q <= ram[ram_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        rdata <= '0;
    else if (state == S_EXEC && op_q == OP_REG_RD) rdata <= regs[reg_ptr];
    else if (state == S_RAM_RDW)                    rdata <= ram_q;
  end

endmodule

// File: tb/tb_regram_xfer_unit.sv
// Bench for regram_xfer_unit: directed vector table, hand-written multi-cycle
// sequences (busy hold, mid-copy reset) and random commands against an array model.
module tb_regram_xfer_unit;
  localparam int REG_D = 16;
  localparam int RAM_D = 64;
  localparam logic [2:0] REG_RD = 3'd0, RAM_RD = 3'd1, REG_WR = 3'd2, RAM_WR = 3'd3;
  localparam logic [2:0] REG_CLR = 3'd4, RAM_CLR = 3'd5, CP_M2R = 3'd6, CP_R2M = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] reg_addr = '0;
  logic [5:0] ram_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_cmds = 0;
  logic mon_en = 1'b0;

  logic [7:0] reg_m [REG_D];
  logic [7:0] ram_m [RAM_D];
  logic [7:0] last_rd = '0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] ra;
    logic [5:0] ma;
    logic [3:0] len;
    logic [7:0] wd;
    int         lat;
    logic       rv;
    logic [7:0] rd;
  } vec_t;

  vec_t vt [$];

  always #5 clk = ~clk;

  regram_xfer_unit #(.DATA_W(8), .REG_AW(4), .RAM_AW(6)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .reg_addr(reg_addr), .ram_addr(ram_addr), .cmd_len(cmd_len),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) n_done++;
    if (mon_en) check("busy_eq_not_ready", busy, !cmd_ready);
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [3:0] ra, input logic [5:0] ma,
                              input logic [3:0] len, input logic [7:0] wd, input int lat,
                              input logic rv, input logic [7:0] rd);
    vec_t v;
    v.op = op; v.ra = ra; v.ma = ma; v.len = len; v.wd = wd; v.lat = lat; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [3:0] len);
    case (op)
      RAM_RD:  return 2;
      REG_CLR: return REG_D;
      RAM_CLR: return RAM_D;
      CP_M2R:  return 2 * (int'(len) + 1);
      CP_R2M:  return int'(len) + 1;
      default: return 1;
    endcase
  endfunction

  task automatic model_apply(input logic [2:0] op, input logic [3:0] ra, input logic [5:0] ma,
                             input logic [3:0] len, input logic [7:0] wd,
                             output logic [7:0] rd, output logic rv);
    rd = '0;
    rv = 1'b0;
    case (op)
      REG_RD:  begin rd = reg_m[ra]; rv = 1'b1; end
      RAM_RD:  begin rd = ram_m[ma]; rv = 1'b1; end
      REG_WR:  reg_m[ra] = wd;
      RAM_WR:  ram_m[ma] = wd;
      REG_CLR: for (int i = 0; i < REG_D; i++) reg_m[i] = '0;
      RAM_CLR: for (int i = 0; i < RAM_D; i++) ram_m[i] = '0;
      CP_M2R:  for (int i = 0; i <= int'(len); i++)
                 reg_m[(int'(ra) + i) % REG_D] = ram_m[(int'(ma) + i) % RAM_D];
      default: for (int i = 0; i <= int'(len); i++)
                 ram_m[(int'(ma) + i) % RAM_D] = reg_m[(int'(ra) + i) % REG_D];
    endcase
  endtask

  task automatic scramble_inputs();
    cmd_op   = 3'($urandom_range(7));
    reg_addr = 4'($urandom_range(15));
    ram_addr = 6'($urandom_range(63));
    cmd_len  = 4'($urandom_range(15));
    wdata    = 8'($urandom_range(255));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] ra, input logic [5:0] ma,
                         input logic [3:0] len, input logic [7:0] wd, input int exp_lat,
                         input logic exp_rv, input logic [7:0] exp_rd, input string tag);
    int   lat;
    int   waitc;
    logic early_rv;
    @(negedge clk);
    waitc = 0;
    while (!cmd_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op; reg_addr = ra; ram_addr = ma; cmd_len = len; wdata = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble_inputs();
    n_cmds++;
    lat = 0;
    early_rv = 1'b0;
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdata_valid && !done) early_rv = 1'b1;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rdata_valid"}, rdata_valid, exp_rv);
    check({tag, "_early_valid"}, early_rv, 0);
    if (exp_rv) begin
      check({tag, "_rdata"}, rdata, exp_rd);
      last_rd = exp_rd;
    end else begin
      check({tag, "_rdata_hold"}, rdata, last_rd);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
  endtask

  task automatic run_model(input logic [2:0] op, input logic [3:0] ra, input logic [5:0] ma,
                           input logic [3:0] len, input logic [7:0] wd, input string tag);
    logic [7:0] rd;
    logic       rv;
    model_apply(op, ra, ma, len, wd, rd, rv);
    run_cmd(op, ra, ma, len, wd, lat_of(op, len), rv, rd, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic       rv;
    logic       seen;
    int         n;

    for (int i = 0; i < REG_D; i++) reg_m[i] = '0;
    for (int i = 0; i < RAM_D; i++) ram_m[i] = '0;

    vt.push_back(mk(REG_RD,  4'd5,  6'd0,  4'd0, 8'h00, 1,  1'b1, 8'h00));
    vt.push_back(mk(RAM_CLR, 4'd0,  6'd0,  4'd0, 8'h00, 64, 1'b0, 8'h00));
    vt.push_back(mk(REG_WR,  4'd5,  6'd0,  4'd0, 8'hA5, 1,  1'b0, 8'h00));
    vt.push_back(mk(REG_RD,  4'd5,  6'd0,  4'd0, 8'h00, 1,  1'b1, 8'hA5));
    vt.push_back(mk(RAM_WR,  4'd0,  6'd10, 4'd0, 8'h3C, 1,  1'b0, 8'h00));
    vt.push_back(mk(RAM_RD,  4'd0,  6'd10, 4'd0, 8'h00, 2,  1'b1, 8'h3C));
    vt.push_back(mk(RAM_WR,  4'd0,  6'd62, 4'd0, 8'h11, 1,  1'b0, 8'h00));
    vt.push_back(mk(RAM_WR,  4'd0,  6'd63, 4'd0, 8'h22, 1,  1'b0, 8'h00));
    vt.push_back(mk(RAM_WR,  4'd0,  6'd0,  4'd0, 8'h33, 1,  1'b0, 8'h00));
    vt.push_back(mk(CP_M2R,  4'd14, 6'd62, 4'd2, 8'h00, 6,  1'b0, 8'h00));
    vt.push_back(mk(REG_RD,  4'd14, 6'd0,  4'd0, 8'h00, 1,  1'b1, 8'h11));
    vt.push_back(mk(REG_RD,  4'd15, 6'd0,  4'd0, 8'h00, 1,  1'b1, 8'h22));
    vt.push_back(mk(REG_RD,  4'd0,  6'd0,  4'd0, 8'h00, 1,  1'b1, 8'h33));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(REG_WR, 4'(3 + i), 6'd0, 4'd0, 8'(1 + i), 1, 1'b0, 8'h00));
    vt.push_back(mk(CP_R2M,  4'd3,  6'd40, 4'd3, 8'h00, 4,  1'b0, 8'h00));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk(RAM_RD, 4'd0, 6'(40 + i), 4'd0, 8'h00, 2, 1'b1, 8'(1 + i)));
    vt.push_back(mk(REG_CLR, 4'd0,  6'd0,  4'd0, 8'h00, 16, 1'b0, 8'h00));
    vt.push_back(mk(REG_RD,  4'd5,  6'd0,  4'd0, 8'h00, 1,  1'b1, 8'h00));
    vt.push_back(mk(RAM_RD,  4'd0,  6'd41, 4'd0, 8'h00, 2,  1'b1, 8'h02));

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rdata_valid", rdata_valid, 0);
    check("reset_rdata", rdata, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      model_apply(vt[k].op, vt[k].ra, vt[k].ma, vt[k].len, vt[k].wd, rd, rv);
      run_cmd(vt[k].op, vt[k].ra, vt[k].ma, vt[k].len, vt[k].wd, vt[k].lat, vt[k].rv, vt[k].rd,
              $sformatf("vec%0d", k));
    end

    // A write held on cmd_valid during RAM_CLR must wait for IDLE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = RAM_CLR; reg_addr = '0; ram_addr = '0; cmd_len = '0;
    @(posedge clk);
    #1;
    cmd_op = REG_WR; reg_addr = 4'd1; wdata = 8'hFF;
    n = 0;
    seen = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (cmd_ready) seen = 1'b1;
    end
    check("hold_clr_latency", n, 64);
    check("hold_ready_while_busy", seen, 0);
    @(posedge clk);
    #1;
    check("hold_ready_at_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    check("hold_accepted_busy", busy, 1);
    check("hold_no_early_done", done, 0);
    @(posedge clk);
    #1;
    check("hold_wr_done", done, 1);
    cmd_valid = 1'b0;
    n_cmds += 2;
    model_apply(RAM_CLR, 4'd0, 6'd0, 4'd0, 8'h00, rd, rv);
    model_apply(REG_WR, 4'd1, 6'd0, 4'd0, 8'hFF, rd, rv);
    run_model(REG_RD, 4'd1, 6'd0, 4'd0, 8'h00, "hold_readback");

    // Random commands against the model
    for (int k = 0; k < 40; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(7));
      if ((op == REG_CLR || op == RAM_CLR) && $urandom_range(3) != 0) op = RAM_RD;
      run_model(op, 4'($urandom_range(15)), 6'($urandom_range(63)), 4'($urandom_range(15)),
                8'($urandom_range(255)), $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a REG->RAM copy
    for (int i = 0; i < 8; i++) run_model(REG_WR, 4'(i), 6'd0, 4'd0, 8'(8'h50 + i), "rst_prep_reg");
    for (int i = 0; i < 8; i++) run_model(RAM_WR, 4'd0, 6'(20 + i), 4'd0, 8'(8'hE0 + i), "rst_prep_ram");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = CP_R2M; reg_addr = 4'd0; ram_addr = 6'd20; cmd_len = 4'd7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    rst = 1'b1;
    #1;
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    for (int i = 0; i < REG_D; i++) reg_m[i] = '0;
    for (int i = 0; i < 3; i++) ram_m[20 + i] = 8'(8'h50 + i);
    last_rd = '0;
    for (int i = 0; i < REG_D; i++) run_model(REG_RD, 4'(i), 6'd0, 4'd0, 8'h00, "midrst_reg");
    for (int i = 0; i < 8; i++) run_model(RAM_RD, 4'd0, 6'(20 + i), 4'd0, 8'h00, "midrst_ram");

    @(negedge clk);
    check("done_pulse_count", n_done, n_cmds);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regram_xfer_unit.md
Name: regram_xfer_unit

Overview:
Parametrised successor to the 16x4 register-file/RAM pair and its mode-driven controller. It holds a flop-based register file and a synchronous RAM behind one command port, and one FSM sequences every operation. Supported operations: single read/write to either store, whole-store clear, and multi-word block copy in either direction. It sits beside the datapath as the scratch-storage/transfer engine.

Parameters:
DATA_W, 8, word width of both stores and of wdata/rdata
REG_AW, 4, register-file address width; depth 2**REG_AW
RAM_AW, 6, RAM address width; depth 2**RAM_AW

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a clk edge
cmd_op  in  3  000 REG_RD, 001 RAM_RD, 010 REG_WR, 011 RAM_WR, 100 REG_CLR, 101 RAM_CLR, 110 COPY_RAM2REG, 111 COPY_REG2RAM
reg_addr  in  REG_AW  register-file address, or start address for copies
ram_addr  in  RAM_AW  RAM address, or start address for copies
cmd_len  in  REG_AW  copy word count minus one (C = cmd_len+1, 1..2**REG_AW); ignored by other ops
wdata  in  DATA_W  write data for REG_WR/RAM_WR
rdata  out  DATA_W  read result; holds until the next read completes
rdata_valid  out  1  one-cycle pulse when rdata is updated
busy  out  1  ~cmd_ready
done  out  1  one-cycle pulse, coincident with the return to IDLE, at the end of every op

Behaviour:
- Reset (async, rst=1): FSM->IDLE; cmd_ready=1, busy=0, done=0, rdata_valid=0, rdata=0; every register-file entry=0. RAM contents are NOT reset; use RAM_CLR to clear them. rst overrides cmd_valid.
- Reset mid-operation: the op aborts immediately; no done pulse; writes already committed remain.
- Command fields are latched at acceptance (edge 0); inputs are don't-care afterwards. cmd_valid while busy is ignored, neither queued nor dropped with an error.
- Register file: synchronous write; combinational read. RAM: synchronous write; registered read with 1-cycle latency.
- FSM states: IDLE, EXEC, RAM_RDW, CLR, CP_RD, CP_WR, FIN.
- FIN asserts done (plus rdata_valid for reads) and goes to IDLE on the next edge.
- Timing below counts edges after acceptance at edge 0; done is high in the cycle after the listed edge, and cmd_ready rises one cycle later.
- REG_WR / RAM_WR: write at edge 1; done after edge 1.
- REG_RD: rdata captured at edge 1; rdata_valid and done after edge 1.
- RAM_RD: RAM read issued at edge 1 (RAM_RDW); rdata captured at edge 2; rdata_valid and done after edge 2.
- REG_CLR / RAM_CLR: the internal counter starts at 0 and zeroes one entry per edge, covering edges 1..2**AW. done follows the last clear, e.g. after edge 16 for REG_CLR at default REG_AW.
- COPY_RAM2REG: 2 edges per word. CP_RD issues the RAM read; CP_WR writes reg[r] <= RAM output. Both addresses then increment. done after edge 2C.
- COPY_REG2RAM: 1 edge per word, ram[m] <= reg[r]; both addresses increment. done after edge C.
- Address arithmetic: copy address counters wrap modulo their store depth independently (reg 15 -> 0, RAM 63 -> 0). No error is raised on wrap. A copy overlapping itself is not possible, because the source and destination are different stores.
- rdata/rdata_valid change only for REG_RD and RAM_RD, never for copies or clears.
- busy = ~cmd_ready at all times; exactly one done pulse per accepted command.

Test Plan:
- Reset, then REG_RD reg 5 -> rdata=0x00, rdata_valid+done one cycle after edge 1; RAM_CLR -> done after edge 64.
- REG_WR reg 5 = 0xA5, then REG_RD reg 5 -> rdata=0xA5 after edge 1; RAM_WR ram 10 = 0x3C, then RAM_RD ram 10 -> rdata=0x3C, valid after edge 2 (not edge 1).
- RAM_WR ram 62=0x11, ram 63=0x22, ram 0=0x33; COPY_RAM2REG ram_addr=62, reg_addr=14, cmd_len=2 -> done after edge 6; reg14=0x11, reg15=0x22, reg0=0x33 (both stores wrap).
- REG_WR reg 3..6 = 1..4; COPY_REG2RAM reg_addr=3, ram_addr=40, cmd_len=3 -> done after edge 4; RAM_RD ram 40..43 = 1..4.
- Hold cmd_valid with REG_WR reg 1=0xFF during a RAM_CLR -> cmd_ready=0 throughout and reg1 unchanged until IDLE, then accepted; busy == ~cmd_ready every cycle.
- Assert rst at edge 3 of COPY_REG2RAM cmd_len=7 -> no done pulse, FSM IDLE, register file all 0, first 3 RAM words written, RAM words 4..8 untouched.
